// File: rtl/dct2_transpose_ctrl.sv
// Handshake sequencer for the 32x32 transpose buffer: loads N_ROWS rows, then drains N_ROWS columns.
// Optional statistics counters are enabled by defining DCT2_TRANSPOSE_CTRL_STATS_EN.
module dct2_transpose_ctrl #(
    parameter int N_ROWS = 32,
    parameter int CNT_W  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tb_enable,
    output logic             tb_direction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_col,
    output logic             out_last,
`ifdef DCT2_TRANSPOSE_CTRL_STATS_EN
    output logic [15:0]      blk_count,
    output logic [15:0]      stall_cnt,
`endif
    output logic [CNT_W-1:0] row_cnt
);

    generate
        if ((2 ** CNT_W) < N_ROWS) begin : g_bad_cnt_w
            $error("CNT_W too narrow for N_ROWS");
        end
    endgenerate

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ROWS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic             row_acc;
    logic             col_acc;

    // A beat is accepted only when flush is low; flush swallows any handshake in its cycle.
    assign row_acc = (state_q == LOAD)  && in_valid  && !flush;
    assign col_acc = (state_q == DRAIN) && out_ready && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD:    if (row_acc && (row_q == LAST_IDX)) state_d = DRAIN;
                DRAIN:   if (col_acc && (col_q == LAST_IDX)) state_d = LOAD;
                default: state_d = LOAD;
            endcase
        end
    end

    always_comb begin
        in_ready     = 1'b0;
        tb_enable    = 1'b0;
        tb_direction = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready  = 1'b1;
                tb_enable = row_acc;
            end
            DRAIN: begin
                tb_direction = 1'b1;
                out_valid    = 1'b1;
                tb_enable    = col_acc;
                out_last     = (col_q == LAST_IDX);
            end
            default: begin
                in_ready = 1'b1;
            end
        endcase
    end

    // Clear on the final beat takes priority over increment, so counters never pass N_ROWS-1.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (flush) begin
            row_d = '0;
            col_d = '0;
        end else begin
            if (row_acc) row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
            if (col_acc) col_d = (col_q == LAST_IDX) ? '0 : col_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign out_col = col_q;
    assign row_cnt = row_q;

`ifdef DCT2_TRANSPOSE_CTRL_STATS_EN
    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blk_count <= '0;
            stall_cnt <= '0;
        end else begin
            if (col_acc && (col_q == LAST_IDX)) begin
                blk_count <= blk_count + 16'd1;
            end
            if ((state_q == DRAIN) && !out_ready && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dct2_transpose_ctrl.sv
// Directed bench for dct2_transpose_ctrl: table-driven full block plus stall, flush and async-reset sequences.
module tb_dct2_transpose_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic       tb_enable;
    logic       tb_direction;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_col;
    logic       out_last;
    logic [4:0] row_cnt;
`ifdef DCT2_TRANSPOSE_CTRL_STATS_EN
    logic [15:0] blk_count;
    logic [15:0] stall_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    dct2_transpose_ctrl #(.N_ROWS(32), .CNT_W(5)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .tb_enable    (tb_enable),
        .tb_direction (tb_direction),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_col      (out_col),
        .out_last     (out_last),
`ifdef DCT2_TRANSPOSE_CTRL_STATS_EN
        .blk_count    (blk_count),
        .stall_cnt    (stall_cnt),
`endif
        .row_cnt      (row_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       fl;
        logic       e_rdy;
        logic       e_en;
        logic       e_dir;
        logic       e_ov;
        logic [4:0] e_col;
        logic       e_last;
        logic [4:0] e_row;
    } vec_t;

    vec_t vecs[65];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_rdy, input logic e_en, input logic e_dir,
                              input logic e_ov, input logic [4:0] e_col, input logic e_last,
                              input logic [4:0] e_row);
        check({tag, ".in_ready"},     32'(in_ready),     32'(e_rdy));
        check({tag, ".tb_enable"},    32'(tb_enable),    32'(e_en));
        check({tag, ".tb_direction"}, 32'(tb_direction), 32'(e_dir));
        check({tag, ".out_valid"},    32'(out_valid),    32'(e_ov));
        check({tag, ".out_col"},      32'(out_col),      32'(e_col));
        check({tag, ".out_last"},     32'(out_last),     32'(e_last));
        check({tag, ".row_cnt"},      32'(row_cnt),      32'(e_row));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of the rising edge.
    task automatic drive(input logic iv, input logic ordy, input logic fl);
        @(negedge clock);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic load_block(input string tag);
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            check_outs($sformatf("%s.row%0d", tag, i), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'(i));
        end
    endtask

    task automatic drain_cols(input string tag, input int from, input int upto);
        for (int c = from; c <= upto; c++) begin
            drive(1'b0, 1'b1, 1'b0);
            check_outs($sformatf("%s.col%0d", tag, c), 1'b0, 1'b1, 1'b1, 1'b1, 5'(c), (c == 31), 5'd0);
        end
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 65; i++) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl);
            check_outs($sformatf("%s[%0d]", tag, i), vecs[i].e_rdy, vecs[i].e_en, vecs[i].e_dir,
                       vecs[i].e_ov, vecs[i].e_col, vecs[i].e_last, vecs[i].e_row);
        end
    endtask

    initial begin
        // Full block with no stalls: rows on cycles 0-31, columns on 32-63, back in LOAD at 64.
        for (int i = 0; i < 32; i++) begin
            vecs[i] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'(i)};
        end
        for (int i = 32; i < 64; i++) begin
            vecs[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'(i - 32), (i == 63), 5'd0};
        end
        vecs[64] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0};

        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            check_outs($sformatf("rst%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_outs("rst_rel", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

        run_table("blk");

        // in_valid toggling: 32 rows over 63 cycles.
        for (int i = 0; i < 63; i++) begin
            logic iv;
            iv = (i % 2 == 0);
            drive(iv, 1'b1, 1'b0);
            check_outs($sformatf("tog%0d", i), 1'b1, iv, 1'b0, 1'b0, 5'd0, 1'b0, 5'((i + 1) / 2));
        end
        drain_cols("tog", 0, 6);
        for (int s = 0; s < 5; s++) begin
            drive(1'b0, 1'b0, 1'b0);
            check_outs($sformatf("stall%0d", s), 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0);
        end
        drain_cols("tog", 7, 31);
        drive(1'b0, 1'b0, 1'b0);
        check_outs("tog_end", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Flush during LOAD at row_cnt=10.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            check_outs($sformatf("fl_load%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'(i));
        end
        drive(1'b1, 1'b0, 1'b1);
        check_outs("fl_load_hit", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd10);
        drive(1'b0, 1'b0, 1'b0);
        check_outs("fl_load_after", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Flush during DRAIN at out_col=20.
        load_block("fl_drain");
        drain_cols("fl_drain", 0, 19);
        drive(1'b0, 1'b1, 1'b1);
        check_outs("fl_drain_hit", 1'b0, 1'b0, 1'b1, 1'b1, 5'd20, 1'b0, 5'd0);
        drive(1'b0, 1'b0, 1'b0);
        check_outs("fl_drain_after", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Asynchronous reset between edges at out_col=15.
        load_block("arst");
        drain_cols("arst", 0, 14);
        drive(1'b0, 1'b0, 1'b0);
        check_outs("arst_pre", 1'b0, 1'b0, 1'b1, 1'b1, 5'd15, 1'b0, 5'd0);
        #2;
        reset = 1'b0;
        #1;
        check_outs("arst_now", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clock);
        reset = 1'b1;
        run_table("post_arst");

`ifdef DCT2_TRANSPOSE_CTRL_STATS_EN
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("stats.blk_rst",   32'(blk_count), 32'd0);
        check("stats.stall_rst", 32'(stall_cnt), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int b = 0; b < 3; b++) begin
            load_block($sformatf("st%0d", b));
            drain_cols($sformatf("st%0d", b), 0, 9);
            for (int s = 0; s < 4; s++) begin
                drive(1'b0, 1'b0, 1'b0);
                check_outs($sformatf("st%0d.stall%0d", b, s), 1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 1'b0, 5'd0);
            end
            drain_cols($sformatf("st%0d", b), 10, 31);
        end
        drive(1'b0, 1'b0, 1'b0);
        check("stats.blk_count", 32'(blk_count), 32'd3);
        check("stats.stall_cnt", 32'(stall_cnt), 32'd12);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check("stats.blk_flush",   32'(blk_count), 32'd3);
        check("stats.stall_flush", 32'(stall_cnt), 32'd12);
        load_block("st_fl");
        drain_cols("st_fl", 0, 2);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check("stats.blk_dflush",   32'(blk_count), 32'd3);
        check("stats.stall_dflush", 32'(stall_cnt), 32'd12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dct2_transpose_ctrl.md
Name: dct2_transpose_ctrl

Overview:
- Sequencer for transpose_buffer_32x32 in the dct2_2d datapath. Sits between the first-pass 1-D DCT (row producer) and the second-pass 1-D DCT (column consumer).
- Accepts 32 row beats over a valid/ready handshake and drives the buffer's enable/direction so each row is written.
- Then presents the 32 transposed columns downstream over a second valid/ready handshake, with column index and last flag.
- Owns no sample data; the 32x16-bit buses run directly between the DCT stages and the buffer.

Parameters:
- N_ROWS, 32, rows per block and columns per block; must equal the transpose buffer dimension.
- CNT_W, 5, width of the row and column counters; must satisfy 2**CNT_W >= N_ROWS.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous abort of the current block.
- in_valid  input  1  upstream row beat valid.
- in_ready  output  1  controller can accept a row.
- tb_enable  output  1  to transpose buffer: shift/capture this cycle.
- tb_direction  output  1  to transpose buffer: 0 = write rows, 1 = read columns.
- out_valid  output  1  buffer outputs hold a valid column.
- out_ready  input  1  downstream accepts the column.
- out_col  output  CNT_W  index of the column currently presented.
- out_last  output  1  presented column is column N_ROWS-1.
- row_cnt  output  CNT_W  rows written in the current block (debug).

Behaviour:
- States: LOAD, DRAIN. While reset=0: state=LOAD, row counter=0, column counter=0.
- Output values with reset asserted and immediately after release: in_ready=1, tb_enable=0, tb_direction=0, out_valid=0, out_col=0, out_last=0, row_cnt=0.
- LOAD:
  - in_ready=1, tb_direction=0, out_valid=0.
  - tb_enable = in_valid, combinational, so the buffer captures the row in the same cycle as the accepting handshake.
  - On each accepted row, the row counter increments.
  - The accepted row with count N_ROWS-1 transitions to DRAIN and clears the row counter.
- DRAIN:
  - in_ready=0, tb_direction=1, out_valid=1.
  - out_col = column counter; out_last = (column counter == N_ROWS-1).
  - Buffer contract: with direction=1 the buffer's out_* show column out_col combinationally; enable advances it to the next column.
  - tb_enable = out_ready, combinational. Each accepted column increments the column counter.
  - Accepting column N_ROWS-1 clears the column counter and returns to LOAD.
- Latency:
  - First column is valid in the cycle after the last row is accepted.
  - With in_valid and out_ready held high, one block takes exactly 2*N_ROWS cycles.
  - Throughput is one beat per cycle in each phase. There is no overlap between LOAD and DRAIN (single buffer).
- Stalls:
  - in_valid=0 in LOAD, or out_ready=0 in DRAIN: tb_enable=0 and counters hold.
  - out_col and out_last remain stable while out_valid=1 and out_ready=0.
- flush=1:
  - Next state is LOAD and both counters clear.
  - tb_enable is forced to 0 in that cycle even if a handshake is present; flush wins and the beat is not counted.
  - Stale buffer contents are overwritten by the next full load.
- Reset asserted mid-block: immediate return to reset values; the partial block is discarded.
- Counter wrap: counters never exceed N_ROWS-1; the clear on the final beat takes priority over increment.

Optional Feature:
- Macro DCT2_TRANSPOSE_CTRL_STATS_EN.
- Defined:
  - Adds output blk_count, 16 bits, reset 0. Increments on each accepted column with out_last=1 and wraps 0xFFFF -> 0x0000.
  - Adds output stall_cnt, 16 bits, reset 0. Increments each DRAIN cycle with out_ready=0 and saturates at 0xFFFF.
  - flush clears neither counter; reset clears both.
- Undefined: neither port exists; the remaining behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release.
  -> In every cycle: in_ready=1, tb_enable=0, tb_direction=0, out_valid=0, out_col=0, row_cnt=0.
- Full block, no stalls: in_valid=1 for 32 cycles, out_ready=1.
  -> tb_enable=1 and tb_direction=0 on cycles 0-31.
  -> out_valid=1 on cycles 32-63 with out_col=0..31; out_last=1 only at cycle 63.
  -> in_ready=1 again at cycle 64.
  -> Feeding row r, column c with value r*32+c, column k arrives as values k, 32+k, ..., 992+k.
- Stalls:
  - in_valid toggles 1/0 per cycle -> 32 rows take 63 cycles and row_cnt advances only on valid cycles.
  - out_ready=0 for 5 cycles at out_col=7 -> out_col holds 7, tb_enable=0, no column is skipped.
- Flush:
  - flush=1 with in_valid=1 at row_cnt=10 -> tb_enable=0 that cycle; next cycle row_cnt=0 in LOAD.
  - flush=1 at out_col=20 in DRAIN -> returns to LOAD, out_valid=0 the next cycle.
- Async reset mid-DRAIN: drive reset=0 between clock edges at out_col=15.
  -> Outputs reach reset values before the next rising edge.
  -> After release, a fresh 32-row block completes normally.
- DCT2_TRANSPOSE_CTRL_STATS_EN defined: 3 blocks, each with 4 out_ready=0 cycles during DRAIN.
  -> blk_count=3, stall_cnt=12.
  -> A flush afterwards leaves both values unchanged.
